// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader that fills instruction memory and holds the CPU in reset until the image is verified
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [2:0] {LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;
  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        acc_q, acc_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              accept;
  assign in_ready   = state_q != DONE && state_q != ERR;
  assign accept     = in_valid && in_ready;
  assign done       = state_q == DONE;
  assign error      = state_q == ERR;
  assign cpu_hold   = state_q != DONE;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;
  // state and datapath registers; async reset drops any partial word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LEN0;
      len_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  // frame parser: length check, word assembly with one-cycle write strobe, checksum compare, reload
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    wc_d    = wc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      LEN0: if (accept) begin
        len_d[7:0] = in_data;
        state_d    = LEN1;
      end
      LEN1: if (accept) begin
        len_d   = {in_data, len_q[7:0]};
        state_d = ({in_data, len_q[7:0]} == 16'd0 || {1'b0, in_data, len_q[7:0]} > DEPTH) ? ERR : DATA;
        wc_d    = '0;
        addr_d  = '0;
        idx_d   = '0;
        acc_d   = '0;
      end
      DATA: if (accept) begin
        acc_d   = acc_q ^ in_data;
        idx_d   = idx_q + 2'd1;
        shift_d = {in_data, shift_q[23:8]};
        if (idx_q == 2'd3) begin
          we_d    = 1'b1;
          addr_d  = wc_q[ADDR_W-1:0];
          wdata_d = {in_data, shift_q};
          wc_d    = wc_q + 1'b1;
          state_d = (16'(wc_q) + 16'd1 == len_q) ? CSUM : DATA;
        end
      end
      CSUM: if (accept) state_d = (in_data == acc_q) ? DONE : ERR;
      DONE, ERR: if (reload) begin
        state_d = LEN0;
        wc_d    = '0;
        acc_d   = '0;
        idx_d   = '0;
      end
      default: state_d = LEN0;
    endcase
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame-level check of imem_loader against a frame model
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        reload = 1'b0;
  logic        in_ready, imem_we, cpu_hold, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;
  logic [39:0] got[$];
  logic [31:0] w[$];
  int          n_chk = 0;
  int          n_pass = 0;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) got.push_back({imem_addr, imem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int pick_gap(input int g);
    return g < 0 ? int'($urandom_range(3, 0)) : g;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input bit rl);
    chk("in_ready_before_byte", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    reload   = rl;
    @(negedge clk);
    in_valid = 1'b0;
    reload   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_frame(input int n, input logic [31:0] ws[$], input bit bad, input int g, input bit mid_rl);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [39:0] exp[$];
    bit          ok;
    bit          good;
    cs   = '0;
    ok   = n >= 1 && n <= 256;
    good = ok && !bad;
    got.delete();
    send_byte(n[7:0], pick_gap(g), 0);
    send_byte(n[15:8], pick_gap(g), 0);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          b  = ws[i][8*k +: 8];
          cs = cs ^ b;
          send_byte(b, pick_gap(g), mid_rl && i == 0 && k == 1);
        end
        exp.push_back({8'(i), ws[i]});
      end
      send_byte(cs ^ {7'b0, bad}, pick_gap(g), 0);
    end
    @(negedge clk);
    chk("write_count", got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      chk("write_addr", got[i][39:32], exp[i][39:32]);
      chk("write_data", got[i][31:0], exp[i][31:0]);
    end
    chk("done", done, good);
    chk("error", error, !good);
    chk("cpu_hold", cpu_hold, !good);
    chk("in_ready_end", in_ready, 0);
    chk("word_count", word_count, ok ? n : 0);
    chk("imem_we_idle", imem_we, 0);
  endtask

  task automatic do_reload;
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_in_ready", in_ready, 1);
    chk("reload_error", error, 0);
    chk("reload_done", done, 0);
    chk("reload_cpu_hold", cpu_hold, 1);
    chk("reload_word_count", word_count, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);
    w = '{32'h00500093, 32'h00A00113};
    run_frame(2, w, 0, 0, 0);
    do_reload();
    run_frame(2, w, 1, 0, 0);
    do_reload();
    run_frame(0, w, 0, 0, 0);
    do_reload();
    run_frame(257, w, 0, 0, 0);
    do_reload();
    w.delete();
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    run_frame(256, w, 0, 0, 0);
    chk("last_addr", got.size() == 256 ? got[255][39:32] : 8'h00, 8'hFF);
    do_reload();
    w = '{32'h00500093, 32'h00A00113};
    run_frame(2, w, 0, 3, 0);
    do_reload();
    got.delete();
    send_byte(8'h02, 0, 0);
    send_byte(8'h00, 0, 0);
    send_byte(8'h93, 0, 0);
    send_byte(8'h00, 0, 0);
    rst = 1'b0;
    #1;
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_word_count", word_count, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_write", got.size(), 0);
    run_frame(2, w, 0, 0, 0);
    do_reload();
    run_frame(2, w, 0, 0, 1);
    do_reload();
    for (int r = 0; r < 10; r++) begin
      int n;
      n = int'($urandom_range(12, 1));
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_frame(n, w, ($urandom % 3) == 0, -1, $urandom % 2);
      do_reload();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
